// File: rtl/uart_echo_tester.sv
// Stop-and-wait loopback initiator: sends an LFSR byte stream through a uart core
// and scores every echoed byte for mismatches, framing errors and timeouts.
module uart_echo_tester #(
    parameter int          Count        = 256,
    parameter logic [7:0]  Seed         = 8'h01,
    parameter int          TimeoutWidth = 16
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    output logic [7:0]  txdata_o,
    output logic        send_o,
    input  logic        txbusy_i,
    input  logic [7:0]  rxdata_i,
    input  logic        ready_i,
    input  logic        rxerr_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic [15:0] errcount_o,
    output logic [7:0]  tocount_o,
    output logic [7:0]  first_exp_o,
    output logic [7:0]  first_got_o
);

    localparam logic [7:0]              SeedEff  = (Seed == 8'h00) ? 8'h01 : Seed;
    localparam logic [15:0]             CountW   = 16'(Count);
    localparam logic [TimeoutWidth-1:0] TimerOne = 1;

    typedef enum logic [2:0] {IDLE, SEND, WAIT, CHECK, DONE} state_t;

    state_t                  state_q, state_d;
    logic [7:0]              lfsr_q, lfsr_d;
    logic [15:0]             index_q, index_d;
    logic [TimeoutWidth-1:0] timer_q, timer_d;
    logic                    got_q, got_d;
    logic                    ferr_q, ferr_d;
    logic [7:0]              rxByte_q, rxByte_d;
    logic                    ready_q, rxerr_q;
    logic [7:0]              txdata_q, txdata_d;
    logic                    send_q, send_d;
    logic                    busy_q, busy_d;
    logic                    pass_q, pass_d;
    logic [15:0]             errCount_q, errCount_d;
    logic [7:0]              toCount_q, toCount_d;
    logic [7:0]              firstExp_q, firstExp_d;
    logic [7:0]              firstGot_q, firstGot_d;
    logic                    firstSeen_q, firstSeen_d;

    logic readyRise, rxerrRise, mismatch, advance;

    function automatic logic [7:0] lfsrNext(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic logic [15:0] satInc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] satInc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign readyRise = ready_i & ~ready_q;
    assign rxerrRise = rxerr_i & ~rxerr_q;
    assign mismatch  = (rxByte_q != lfsr_q);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            lfsr_q      <= SeedEff;
            index_q     <= '0;
            timer_q     <= '0;
            got_q       <= 1'b0;
            ferr_q      <= 1'b0;
            rxByte_q    <= '0;
            ready_q     <= 1'b0;
            rxerr_q     <= 1'b0;
            txdata_q    <= '0;
            send_q      <= 1'b0;
            busy_q      <= 1'b0;
            pass_q      <= 1'b0;
            errCount_q  <= '0;
            toCount_q   <= '0;
            firstExp_q  <= '0;
            firstGot_q  <= '0;
            firstSeen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            index_q     <= index_d;
            timer_q     <= timer_d;
            got_q       <= got_d;
            ferr_q      <= ferr_d;
            rxByte_q    <= rxByte_d;
            ready_q     <= ready_i;
            rxerr_q     <= rxerr_i;
            txdata_q    <= txdata_d;
            send_q      <= send_d;
            busy_q      <= busy_d;
            pass_q      <= pass_d;
            errCount_q  <= errCount_d;
            toCount_q   <= toCount_d;
            firstExp_q  <= firstExp_d;
            firstGot_q  <= firstGot_d;
            firstSeen_q <= firstSeen_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        index_d     = index_q;
        timer_d     = timer_q;
        got_d       = got_q;
        ferr_d      = ferr_q;
        rxByte_d    = rxByte_q;
        txdata_d    = txdata_q;
        send_d      = send_q;
        busy_d      = busy_q;
        pass_d      = pass_q;
        errCount_d  = errCount_q;
        toCount_d   = toCount_q;
        firstExp_d  = firstExp_q;
        firstGot_d  = firstGot_q;
        firstSeen_d = firstSeen_q;
        advance     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    errCount_d  = '0;
                    toCount_d   = '0;
                    firstExp_d  = '0;
                    firstGot_d  = '0;
                    firstSeen_d = 1'b0;
                    pass_d      = 1'b0;
                    index_d     = '0;
                    lfsr_d      = SeedEff;
                    busy_d      = 1'b1;
                    if (CountW == 16'd0) begin
                        state_d = DONE;
                    end else begin
                        state_d  = SEND;
                        txdata_d = SeedEff;
                        send_d   = 1'b1;
                    end
                end
            end
            SEND: begin
                if (txbusy_i) begin
                    send_d  = 1'b0;
                    state_d = WAIT;
                    timer_d = '0;
                    got_d   = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            WAIT: begin
                timer_d = timer_q + TimerOne;
                if (readyRise) begin
                    got_d    = 1'b1;
                    rxByte_d = rxdata_i;
                end
                if (rxerrRise) begin
                    ferr_d = 1'b1;
                end
                if (got_q && !txbusy_i) begin
                    state_d = CHECK;
                end else if (!got_q && (&timer_q)) begin
                    toCount_d  = satInc8(toCount_q);
                    errCount_d = satInc16(errCount_q);
                    advance    = 1'b1;
                end
            end
            CHECK: begin
                if (mismatch || ferr_q) begin
                    errCount_d = satInc16(errCount_q);
                end
                // Only a data mismatch is recorded; a framing error alone leaves first_* alone.
                if (mismatch && !firstSeen_q) begin
                    firstSeen_d = 1'b1;
                    firstExp_d  = lfsr_q;
                    firstGot_d  = rxByte_q;
                end
                advance = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (advance) begin
            lfsr_d  = lfsrNext(lfsr_q);
            index_d = index_q + 16'd1;
            if (index_d == CountW) begin
                state_d = DONE;
            end else begin
                state_d  = SEND;
                txdata_d = lfsr_d;
                send_d   = 1'b1;
            end
        end

        // Results settle on entry to DONE so they are valid alongside the done pulse.
        if (state_d == DONE && state_q != DONE) begin
            busy_d = 1'b0;
            pass_d = (errCount_d == 16'd0);
        end
    end

    assign txdata_o    = txdata_q;
    assign send_o      = send_q;
    assign busy_o      = busy_q;
    assign done_o      = (state_q == DONE);
    assign pass_o      = pass_q;
    assign errcount_o  = errCount_q;
    assign tocount_o   = toCount_q;
    assign first_exp_o = firstExp_q;
    assign first_got_o = firstGot_q;

endmodule
